// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous pulse in clk cycles and hands the
// result to a valid/ready consumer, with glitch counting and overrun tracking.
module pulse_width_meter #(
    parameter int MIN_WIDTH   = 2,
    parameter int MAX_WIDTH   = 1023,
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = $clog2(MAX_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse_in,
    input  logic             clear,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] width_out,
    output logic             too_long,
    output logic             overrun,
    output logic [7:0]       glitch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_WIDTH);
    localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [WIDTH-1:0]       width_q, width_d;
    logic                   too_long_q, too_long_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             glitch_q, glitch_d;

    logic                   s;
    logic                   rise;
    logic                   emit;
    logic [WIDTH-1:0]       emit_width;
    logic                   emit_too_long;
    logic                   glitch_event;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
        s_d_d  = s;
    end

    // Measurement FSM: the counter starts at 1 on the rising edge so a run of
    // N high samples leaves cnt=N when the first low sample arrives.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        emit          = 1'b0;
        emit_width    = cnt_q;
        emit_too_long = 1'b0;
        glitch_event  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = WIDTH'(1);
                end
            end
            MEASURE: begin
                if (s) begin
                    if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        emit          = 1'b1;
                        emit_width    = MAX_CNT;
                        emit_too_long = 1'b1;
                        state_d       = STUCK;
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= MIN_CNT) begin
                        emit = 1'b1;
                    end else begin
                        glitch_event = 1'b1;
                    end
                end
            end
            STUCK: begin
                if (!s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register: a transfer and a new emit in the same cycle reload
    // without a bubble; clear takes priority over overrun and glitch updates.
    always_comb begin
        valid_d    = valid_q;
        width_d    = width_q;
        too_long_d = too_long_q;
        overrun_d  = overrun_q;
        glitch_d   = glitch_q;
        if (emit && (!valid_q || ready)) begin
            valid_d    = 1'b1;
            width_d    = emit_width;
            too_long_d = emit_too_long;
        end else if (emit) begin
            overrun_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (glitch_event && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
        if (clear) begin
            overrun_d = 1'b0;
            glitch_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            width_q    <= '0;
            too_long_q <= 1'b0;
            overrun_q  <= 1'b0;
            glitch_q   <= 8'd0;
        end else begin
            sync_q     <= sync_d;
            s_d_q      <= s_d_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            width_q    <= width_d;
            too_long_q <= too_long_d;
            overrun_q  <= overrun_d;
            glitch_q   <= glitch_d;
        end
    end

    assign valid        = valid_q;
    assign width_out    = width_q;
    assign too_long     = too_long_q;
    assign overrun      = overrun_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: a default instance plus a short
// MAX_WIDTH=15 instance for the too-long path.
module tb_pulse_width_meter;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       pulse_a, ready_a;
    logic       valid_a, too_long_a, overrun_a;
    logic [9:0] width_a;
    logic [7:0] glitch_a;
    logic       pulse_b;
    logic       valid_b, too_long_b, overrun_b;
    logic [3:0] width_b;
    logic [7:0] glitch_b;

    int errors = 0;
    int checks = 0;
    int results_a = 0;
    int results_b = 0;

    logic [10:0] exp_a[$];
    logic [4:0]  exp_b[$];

    pulse_width_meter dut (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_a), .clear(clear),
        .ready(ready_a), .valid(valid_a), .width_out(width_a),
        .too_long(too_long_a), .overrun(overrun_a), .glitch_count(glitch_a)
    );

    pulse_width_meter #(.MAX_WIDTH(15)) dut_b (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_b), .clear(clear),
        .ready(1'b1), .valid(valid_b), .width_out(width_b),
        .too_long(too_long_b), .overrun(overrun_b), .glitch_count(glitch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Every accepted transfer pops the oldest expected result.
    always @(negedge clk) begin
        if (reset_n && valid_a && ready_a) begin
            results_a++;
            if (exp_a.size() == 0) begin
                check_output("unexpected_result_a", 1, 0);
            end else begin
                logic [10:0] e;
                e = exp_a.pop_front();
                check_output("width_a", 32'(width_a), 32'(e[9:0]));
                check_output("too_long_a", 32'(too_long_a), 32'(e[10]));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && valid_b) begin
            results_b++;
            if (exp_b.size() == 0) begin
                check_output("unexpected_result_b", 1, 0);
            end else begin
                logic [4:0] e;
                e = exp_b.pop_front();
                check_output("width_b", 32'(width_b), 32'(e[3:0]));
                check_output("too_long_b", 32'(too_long_b), 32'(e[4]));
            end
        end
    end

    task automatic drive_pulse_a(input int n);
        @(posedge clk);
        #1 pulse_a = 1'b1;
        repeat (n) @(posedge clk);
        #1 pulse_a = 1'b0;
    endtask

    task automatic drive_pulse_b(input int n);
        @(posedge clk);
        #1 pulse_b = 1'b1;
        repeat (n) @(posedge clk);
        #1 pulse_b = 1'b0;
    endtask

    task automatic apply_stimulus(input int n, input int gap);
        if (n >= 2) begin
            exp_a.push_back({1'b0, 10'(n)});
        end
        drive_pulse_a(n);
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        int base;
        int lat;
        reset_n = 1'b0;
        clear   = 1'b0;
        pulse_a = 1'b0;
        pulse_b = 1'b0;
        ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", 32'(valid_a), 0);
        check_output("reset_width", 32'(width_a), 0);
        check_output("reset_too_long", 32'(too_long_a), 0);
        check_output("reset_overrun", 32'(overrun_a), 0);
        check_output("reset_glitch", 32'(glitch_a), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // 10-cycle pulse: one result, valid three edges after the fall
        base = results_a;
        exp_a.push_back({1'b0, 10'd10});
        drive_pulse_a(10);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (valid_a && lat == 0) lat = i;
        end
        check_output("valid_latency", 32'(lat), 3);
        check_output("single_strobe", 32'(results_a - base), 1);

        apply_stimulus(2, 6);
        apply_stimulus(3, 6);
        apply_stimulus(50, 6);
        apply_stimulus(1, 6);
        #1 check_output("glitch_one", 32'(glitch_a), 1);

        // 255 more one-cycle pulses saturate the glitch counter
        for (int i = 0; i < 255; i++) begin
            apply_stimulus(1, 3);
        end
        repeat (5) @(posedge clk);
        #1 check_output("glitch_saturate", 32'(glitch_a), 255);
        pulse_clear();
        check_output("glitch_cleared", 32'(glitch_a), 0);

        // Too-long pulse on the MAX_WIDTH=15 instance, then a normal one
        exp_b.push_back({1'b1, 4'd15});
        drive_pulse_b(40);
        repeat (8) @(posedge clk);
        #1;
        check_output("too_long_count", 32'(results_b), 1);
        check_output("too_long_valid_gone", 32'(valid_b), 0);
        exp_b.push_back({1'b0, 4'd6});
        drive_pulse_b(6);
        repeat (8) @(posedge clk);
        #1 check_output("after_stuck_count", 32'(results_b), 2);

        // Held result with ready low: second result dropped, overrun set
        ready_a = 1'b0;
        apply_stimulus(5, 6);
        drive_pulse_a(7);
        repeat (6) @(posedge clk);
        #1;
        check_output("held_valid", 32'(valid_a), 1);
        check_output("held_width", 32'(width_a), 5);
        check_output("held_too_long", 32'(too_long_a), 0);
        check_output("overrun_set", 32'(overrun_a), 1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 check_output("valid_dropped", 32'(valid_a), 0);
        pulse_clear();
        check_output("overrun_cleared", 32'(overrun_a), 0);

        // Build up state, then reset in the middle of a 20-cycle pulse
        ready_a = 1'b0;
        drive_pulse_a(1);
        repeat (4) @(posedge clk);
        drive_pulse_a(4);
        repeat (6) @(posedge clk);
        drive_pulse_a(4);
        repeat (6) @(posedge clk);
        #1;
        check_output("pre_reset_valid", 32'(valid_a), 1);
        check_output("pre_reset_overrun", 32'(overrun_a), 1);
        check_output("pre_reset_glitch", 32'(glitch_a), 1);
        @(posedge clk);
        #1 pulse_a = 1'b1;
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_output("midreset_valid", 32'(valid_a), 0);
        check_output("midreset_width", 32'(width_a), 0);
        check_output("midreset_too_long", 32'(too_long_a), 0);
        check_output("midreset_overrun", 32'(overrun_a), 0);
        check_output("midreset_glitch", 32'(glitch_a), 0);
        repeat (3) @(posedge clk);
        #1;
        ready_a = 1'b1;
        reset_n = 1'b1;
        exp_a.push_back({1'b0, 10'd9});
        repeat (9) @(posedge clk);
        #1 pulse_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        check_output("pending_a", 32'(exp_a.size()), 0);
        check_output("pending_b", 32'(exp_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
